// File: rtl/instruction_fetch_unit.sv
// MIPS program counter and IF/ID pipeline register.
// Fetches from a combinational instruction memory and handles stall, redirect and halt.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PCOut,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ifid_instr;
    logic [31:0] w_ifid_instr_nxt;
    logic [31:0] r_ifid_pc4;
    logic [31:0] w_ifid_pc4_nxt;
    logic        r_ifid_vld;
    logic        w_ifid_vld_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_is_halt;

    // Jump has priority over a simultaneous branch; targets are word aligned.
    assign w_redirect = Jump | BranchTaken;
    assign w_target   = Jump ? {JumpTarget[31:2], 2'b00} : {BranchTarget[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_is_halt  = (Instruction[31:26] == HALT_OPCODE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_vld   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_vld   <= w_ifid_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_vld_nxt   = r_ifid_vld;
        if (w_redirect) begin
            w_state_nxt      = ST_RUN;
            w_pc_nxt         = w_target;
            w_ifid_instr_nxt = 32'd0;
            w_ifid_pc4_nxt   = 32'd0;
            w_ifid_vld_nxt   = 1'b0;
        end else if (!Stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_is_halt) begin
                        // The halt word is swallowed here and never reaches decode.
                        w_state_nxt      = ST_HALTED;
                        w_ifid_instr_nxt = 32'd0;
                        w_ifid_pc4_nxt   = 32'd0;
                        w_ifid_vld_nxt   = 1'b0;
                    end else begin
                        w_pc_nxt         = w_pc_plus4;
                        w_ifid_instr_nxt = Instruction;
                        w_ifid_pc4_nxt   = w_pc_plus4;
                        w_ifid_vld_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_ifid_instr_nxt = 32'd0;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_vld_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign PCOut             = r_pc;
    assign IF_ID_Instruction = r_ifid_instr;
    assign IF_ID_PCPlus4     = r_ifid_pc4;
    assign IF_ID_Valid       = r_ifid_vld;
    assign Halted            = (r_state == ST_HALTED);

endmodule
